// File: rtl/score_keeper.sv
// Score keeper for a tower-stacking game: survival ticks, perfect-drop combos,
// packed-BCD score with saturation, and a high score latched when a game ends.
module score_keeper #(
   parameter int DIGITS    = 4,
   parameter int TICK_DIV  = 50000000,
   parameter int MAX_COMBO = 7
) (
   input  logic                work_clk,
   input  logic                rst_n,
   input  logic [1:0]          scene,
   input  logic                drop_ok,
   input  logic                drop_perfect,
   output logic [4*DIGITS-1:0] score,
   output logic [4*DIGITS-1:0] high_score,
   output logic [2:0]          combo,
   output logic                new_record,
   output logic                saturated,
   output logic [1:0]          state
);

   localparam int                  PW         = $clog2(TICK_DIV);
   localparam logic [PW-1:0]       PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [2:0]          COMBO_MAX  = 3'(MAX_COMBO);
   localparam logic [4*DIGITS-1:0] ALL_NINES  = {DIGITS{4'h9}};

   typedef enum logic [1:0] {
      MENU  = 2'd0,
      PLAY  = 2'd1,
      OVER  = 2'd2,
      PAUSE = 2'd3
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [PW-1:0]       presc_q;
   logic [PW-1:0]       presc_d;
   logic [4*DIGITS-1:0] score_d;
   logic [4*DIGITS-1:0] high_d;
   logic [4*DIGITS-1:0] sum_bcd;
   logic [2:0]          combo_d;
   logic                nr_d;
   logic                sat_d;
   logic                in_play;
   logic                new_game;
   logic                game_end;
   logic                tick;
   logic                drop;
   logic [3:0]          drop_pts;
   logic [3:0]          inc;
   logic [3:0]          carry;
   logic [4:0]          dsum;

   assign state = state_q;

   always_ff @(posedge work_clk) begin
      if (!rst_n) begin
         state_q <= MENU;
      end else begin
         state_q <= state_d;
      end
   end

   // The state simply follows scene; entry actions decode (old state, scene).
   always_comb begin
      state_d  = state_t'(scene);
      in_play  = (state_q == PLAY);
      new_game = (state_d == PLAY) && ((state_q == MENU) || (state_q == OVER));
      game_end = (state_d == OVER) && ((state_q == PLAY) || (state_q == PAUSE));
   end

   always_comb begin
      tick     = in_play && (presc_q == PRESC_LAST);
      drop     = in_play && drop_ok;
      drop_pts = 4'd0;
      combo_d  = combo;
      presc_d  = presc_q;
      if (in_play) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
      end
      if (drop) begin
         if (drop_perfect) begin
            drop_pts = {1'b0, combo} + 4'd1;
            combo_d  = (combo >= COMBO_MAX) ? COMBO_MAX : combo + 3'd1;
         end else begin
            drop_pts = 4'd1;
            combo_d  = 3'd0;
         end
      end
      inc = {3'b000, tick} + drop_pts;

      // Increment never exceeds 9, so one pass of single-digit BCD adds suffices.
      sum_bcd = '0;
      dsum    = '0;
      carry   = inc;
      for (int i = 0; i < DIGITS; i++) begin
         dsum = {1'b0, score[4*i +: 4]} + {1'b0, carry};
         if (dsum > 5'd9) begin
            sum_bcd[4*i +: 4] = 4'(dsum - 5'd10);
            carry             = 4'd1;
         end else begin
            sum_bcd[4*i +: 4] = dsum[3:0];
            carry             = 4'd0;
         end
      end

      score_d = score;
      sat_d   = saturated;
      nr_d    = new_record;
      high_d  = high_score;
      if ((inc != 4'd0) && !saturated) begin
         if (carry != 4'd0) begin
            score_d = ALL_NINES;
            sat_d   = 1'b1;
         end else begin
            score_d = sum_bcd;
            sat_d   = (sum_bcd == ALL_NINES);
         end
      end

      if (new_game) begin
         score_d = '0;
         combo_d = 3'd0;
         presc_d = '0;
         sat_d   = 1'b0;
         nr_d    = 1'b0;
      end

      // Valid packed BCD orders the same as plain binary, so a binary compare works.
      if (game_end && (score_d > high_score)) begin
         high_d = score_d;
         nr_d   = 1'b1;
      end
   end

   always_ff @(posedge work_clk) begin
      if (!rst_n) begin
         presc_q    <= '0;
         score      <= '0;
         high_score <= '0;
         combo      <= 3'd0;
         new_record <= 1'b0;
         saturated  <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         score      <= score_d;
         high_score <= high_d;
         combo      <= combo_d;
         new_record <= nr_d;
         saturated  <= sat_d;
      end
   end

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: a decimal reference model feeds a per-cycle expected
// queue, and a vector table adds hand-derived checkpoints along the game flow.
module tb_score_keeper;

   localparam int DIGITS    = 4;
   localparam int TICK_DIV  = 4;
   localparam int MAX_COMBO = 7;
   localparam int MAX_SCORE = 9999;

   logic        work_clk = 1'b0;
   logic        rst_n;
   logic [1:0]  scene;
   logic        drop_ok;
   logic        drop_perfect;
   logic [15:0] score;
   logic [15:0] high_score;
   logic [2:0]  combo;
   logic        new_record;
   logic        saturated;
   logic [1:0]  state;

   score_keeper #(
      .DIGITS   (DIGITS),
      .TICK_DIV (TICK_DIV),
      .MAX_COMBO(MAX_COMBO)
   ) dut (
      .work_clk    (work_clk),
      .rst_n       (rst_n),
      .scene       (scene),
      .drop_ok     (drop_ok),
      .drop_perfect(drop_perfect),
      .score       (score),
      .high_score  (high_score),
      .combo       (combo),
      .new_record  (new_record),
      .saturated   (saturated),
      .state       (state)
   );

   always #5 work_clk = ~work_clk;

   typedef struct {
      logic        rst;
      logic [1:0]  sc;
      logic        ok;
      logic        pf;
      int          reps;
      logic [15:0] e_score;
      logic [15:0] e_hs;
      logic [2:0]  e_combo;
      logic        e_nr;
      logic        e_sat;
      logic [1:0]  e_state;
   } vec_t;

   vec_t        vecs[28];
   logic [38:0] exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   int m_state = 0;
   int m_score = 0;
   int m_hs    = 0;
   int m_combo = 0;
   int m_presc = 0;
   bit m_nr    = 1'b0;
   bit m_sat   = 1'b0;

   function automatic vec_t mk(input logic r, input logic [1:0] sc, input logic ok, input logic pf,
                               input int reps, input logic [15:0] s, input logic [15:0] h,
                               input logic [2:0] c, input logic nr, input logic sat, input logic [1:0] st);
      vec_t v;
      v = '{r, sc, ok, pf, reps, s, h, c, nr, sat, st};
      return v;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int          x;
      r = '0;
      x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x           = x / 10;
      end
      return r;
   endfunction

   function automatic logic [38:0] pack(input logic [15:0] s, input logic [15:0] h, input logic [2:0] c,
                                        input logic nr, input logic sat, input logic [1:0] st);
      return {s, h, c, nr, sat, st};
   endfunction

   task automatic model_step(input logic r, input logic [1:0] sc, input logic ok, input logic pf);
      int inc;
      bit play, ng, ge, tk;
      if (!r) begin
         m_state = 0; m_score = 0; m_hs = 0; m_combo = 0; m_presc = 0; m_nr = 0; m_sat = 0;
      end else begin
         play = (m_state == 1);
         ng   = (sc == 2'd1) && (m_state == 0 || m_state == 2);
         ge   = (sc == 2'd2) && (m_state == 1 || m_state == 3);
         tk   = play && (m_presc == TICK_DIV - 1);
         inc  = tk ? 1 : 0;
         if (play) m_presc = tk ? 0 : m_presc + 1;
         if (play && ok) begin
            if (pf) begin
               inc    += m_combo + 1;
               m_combo = (m_combo + 1 > MAX_COMBO) ? MAX_COMBO : m_combo + 1;
            end else begin
               inc    += 1;
               m_combo = 0;
            end
         end
         if (inc > 0 && !m_sat) begin
            m_score += inc;
            if (m_score >= MAX_SCORE) begin
               m_score = MAX_SCORE;
               m_sat   = 1'b1;
            end
         end
         if (ng) begin
            m_score = 0; m_combo = 0; m_presc = 0; m_sat = 0; m_nr = 0;
         end
         if (ge && m_score > m_hs) begin
            m_hs = m_score;
            m_nr = 1'b1;
         end
         m_state = int'(sc);
      end
   endtask

   function automatic logic [38:0] dut_now();
      return pack(score, high_score, combo, new_record, saturated, state);
   endfunction

   task automatic report(input string name, input logic [38:0] got, input logic [38:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s t=%0t got score=%h hs=%h combo=%0d nr=%b sat=%b state=%0d want score=%h hs=%h combo=%0d nr=%b sat=%b state=%0d",
                  name, $time, got[38:23], got[22:7], got[6:4], got[3], got[2], got[1:0],
                  want[38:23], want[22:7], want[6:4], want[3], want[2], want[1:0]);
      end
   endtask

   task automatic step(input logic r, input logic [1:0] sc, input logic ok, input logic pf);
      logic [38:0] want;
      rst_n        = r;
      scene        = sc;
      drop_ok      = ok;
      drop_perfect = pf;
      model_step(r, sc, ok, pf);
      exp_q.push_back(pack(to_bcd(m_score), to_bcd(m_hs), 3'(m_combo), m_nr, m_sat, 2'(m_state)));
      @(posedge work_clk);
      #1;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL sb_empty t=%0t got none want an entry", $time);
      end else begin
         want = exp_q.pop_front();
         report("cycle", dut_now(), want);
      end
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         for (int k = 0; k < vecs[i].reps; k++) begin
            step(vecs[i].rst, vecs[i].sc, vecs[i].ok, vecs[i].pf);
         end
         report($sformatf("row%0d", i), dut_now(),
                pack(vecs[i].e_score, vecs[i].e_hs, vecs[i].e_combo, vecs[i].e_nr, vecs[i].e_sat, vecs[i].e_state));
      end
   endtask

   initial begin
      int guard;
      rst_n = 1'b0; scene = 2'd0; drop_ok = 1'b0; drop_perfect = 1'b0;

      vecs[0]  = mk(0, 0, 0, 0,   2, 16'h0000, 16'h0000, 0, 0, 0, 0);
      vecs[1]  = mk(1, 0, 0, 0,   1, 16'h0000, 16'h0000, 0, 0, 0, 0);
      vecs[2]  = mk(1, 1, 0, 0,   1, 16'h0000, 16'h0000, 0, 0, 0, 1);
      vecs[3]  = mk(1, 1, 0, 0,  40, 16'h0010, 16'h0000, 0, 0, 0, 1);
      vecs[4]  = mk(1, 2, 0, 0,   1, 16'h0060, 16'h0060, 0, 1, 0, 2);
      vecs[5]  = mk(1, 2, 0, 0,   3, 16'h0060, 16'h0060, 0, 1, 0, 2);
      vecs[6]  = mk(1, 1, 0, 0,   1, 16'h0000, 16'h0060, 0, 0, 0, 1);
      vecs[7]  = mk(1, 1, 0, 0, 122, 16'h0030, 16'h0060, 0, 0, 0, 1);
      vecs[8]  = mk(1, 3, 0, 0,   1, 16'h0030, 16'h0060, 0, 0, 0, 3);
      vecs[9]  = mk(1, 3, 1, 1,  19, 16'h0030, 16'h0060, 0, 0, 0, 3);
      vecs[10] = mk(1, 1, 0, 0,   1, 16'h0030, 16'h0060, 0, 0, 0, 1);
      vecs[11] = mk(1, 1, 0, 0,   1, 16'h0031, 16'h0060, 0, 0, 0, 1);
      vecs[12] = mk(1, 1, 0, 0, 116, 16'h0060, 16'h0060, 0, 0, 0, 1);
      vecs[13] = mk(1, 2, 0, 0,   1, 16'h0060, 16'h0060, 0, 0, 0, 2);
      vecs[14] = mk(1, 1, 0, 0,   1, 16'h0000, 16'h0060, 0, 0, 0, 1);
      vecs[15] = mk(1, 1, 1, 1,  12, 16'h0071, 16'h0060, 7, 0, 0, 1);
      vecs[16] = mk(1, 0, 0, 0,   1, 16'h0071, 16'h0060, 7, 0, 0, 0);
      vecs[17] = mk(1, 2, 0, 0,   1, 16'h0071, 16'h0060, 7, 0, 0, 2);
      vecs[18] = mk(1, 2, 1, 1,   2, 16'h0071, 16'h0060, 7, 0, 0, 2);
      vecs[19] = mk(1, 1, 0, 0,   1, 16'h0000, 16'h0060, 0, 0, 0, 1);
      vecs[20] = mk(1, 2, 0, 0,   1, 16'h9999, 16'h9999, 0, 1, 1, 2);
      vecs[21] = mk(1, 1, 0, 0,   1, 16'h0000, 16'h9999, 0, 0, 0, 1);
      vecs[22] = mk(1, 1, 1, 1,   5, 16'h0016, 16'h9999, 5, 0, 0, 1);
      vecs[23] = mk(0, 1, 1, 0,   1, 16'h0000, 16'h0000, 0, 0, 0, 0);
      vecs[24] = mk(1, 1, 0, 0,   1, 16'h0000, 16'h0000, 0, 0, 0, 1);
      vecs[25] = mk(1, 1, 0, 0,   3, 16'h0000, 16'h0000, 0, 0, 0, 1);
      vecs[26] = mk(1, 1, 1, 0,   2, 16'h0003, 16'h0000, 0, 0, 0, 1);
      vecs[27] = mk(0, 2, 0, 0,   1, 16'h0000, 16'h0000, 0, 0, 0, 0);

      run_rows(0, 3);

      // Nine perfect drops two cycles apart, then one plain drop.
      for (int i = 0; i < 9; i++) begin
         step(1, 1, 1, 1);
         step(1, 1, 0, 0);
      end
      report("combo_peak", dut_now(), pack(16'h0058, 16'h0000, 3'd7, 1'b0, 1'b0, 2'd1));
      step(1, 1, 1, 0);
      step(1, 1, 0, 0);
      report("combo_clear", dut_now(), pack(16'h0060, 16'h0000, 3'd0, 1'b0, 1'b0, 2'd1));

      run_rows(4, 19);

      // Climb towards the top of the range, then push past it.
      guard = 0;
      while ((m_score + 9 < MAX_SCORE) && (guard < 3000)) begin
         step(1, 1, 1, 1);
         guard++;
      end
      if (guard >= 3000) begin
         n_cmp++;
         n_bad++;
         $display("FAIL climb_budget got score=%h want near %0d", score, MAX_SCORE);
      end
      report("pre_sat", {38'b0, saturated}, 39'b0);
      repeat (3) step(1, 1, 1, 1);
      report("sat_hit", dut_now(), pack(16'h9999, 16'h0060, 3'd7, 1'b0, 1'b1, 2'd1));
      step(1, 1, 1, 0);
      repeat (4) step(1, 1, 0, 0);
      report("sat_hold", dut_now(), pack(16'h9999, 16'h0060, 3'd0, 1'b0, 1'b1, 2'd1));

      run_rows(20, 27);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
